// File: rtl/game_pkg.sv
// Shared 2048 game types: move codes and the move-encoder FSM states.
package game_pkg;

   typedef enum logic [2:0] {
      MovNone  = 3'd0,
      MovLeft  = 3'd1,
      MovRight = 3'd2,
      MovUp    = 3'd3,
      MovDown  = 3'd4
   } mov_t;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StWaitRelease
   } menc_state_t;

   // btn = {down, up, right, left}; left wins over right over up over down
   function automatic mov_t prio_encode(input logic [3:0] btn);
      mov_t code;
      code = MovNone;
      if (btn[0])      code = MovLeft;
      else if (btn[1]) code = MovRight;
      else if (btn[2]) code = MovUp;
      else if (btn[3]) code = MovDown;
      return code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw button.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter only runs while the synced level disagrees and stops at the flip point,
   // so it can never wrap.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q >= CntLast) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/move_encoder.sv
// Turns four debounced direction buttons into one held move request with valid/ack.
module move_encoder
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_izq,
   input  logic btn_der,
   input  logic btn_up,
   input  logic btn_down,
   input  logic enable,
   input  logic mov_ack,
   output mov_t mov,
   output logic mov_valid
);

   logic [3:0]  raw_btn;
   logic [3:0]  lvl;
   menc_state_t state_q, state_d;
   mov_t        mov_q, mov_d;

   assign raw_btn = {btn_down, btn_up, btn_der, btn_izq};

   for (genvar i = 0; i < 4; i++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_btn[i]),
         .level(lvl[i])
      );
   end

   always_comb begin
      state_d = state_q;
      mov_d   = mov_q;
      unique case (state_q)
         StIdle: begin
            if (enable && (|lvl)) begin
               state_d = StHold;
               mov_d   = prio_encode(lvl);
            end
         end
         StHold: begin
            // Ack and withdrawal both end the request the same way.
            if (mov_ack || !enable) begin
               state_d = StWaitRelease;
               mov_d   = MovNone;
            end
         end
         StWaitRelease: begin
            if (!(|lvl)) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            mov_d   = MovNone;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         mov_q   <= MovNone;
      end else begin
         state_q <= state_d;
         mov_q   <= mov_d;
      end
   end

   assign mov       = mov_q;
   assign mov_valid = (state_q == StHold);

endmodule

// File: tb/tb_move_encoder.sv
// Directed bench for move_encoder with DEBOUNCE_CYCLES = 4.
module tb_move_encoder;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_izq = 1'b0, btn_der = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic enable = 1'b1;
   logic mov_ack = 1'b0;
   mov_t mov;
   logic mov_valid;

   int n_pass = 0;
   int n_total = 0;

   move_encoder #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_izq  (btn_izq),
      .btn_der  (btn_der),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .enable   (enable),
      .mov_ack  (mov_ack),
      .mov      (mov),
      .mov_valid(mov_valid)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] m);
      check({tag, ".valid"}, 32'(mov_valid), 32'(v));
      check({tag, ".mov"}, 32'(mov), m);
   endtask

   initial begin
      logic seen;

      // Reset state
      #2;
      check_out("reset", 1'b0, 32'd0);
      step(3);
      check_out("reset_held", 1'b0, 32'd0);
      rst = 1'b1;
      step(5);
      check_out("idle", 1'b0, 32'd0);

      // Ack outside HOLD is ignored
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      check_out("ack_idle", 1'b0, 32'd0);

      // Left press: valid after edge k+6
      btn_izq = 1'b1;
      step(6);
      check_out("left_early", 1'b0, 32'd0);
      step(1);
      check_out("left_valid", 1'b1, 32'd1);
      step(20);
      check_out("left_hold", 1'b1, 32'd1);
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      check_out("left_ack", 1'b0, 32'd0);
      step(15);
      check_out("left_no_retrig", 1'b0, 32'd0);
      btn_izq = 1'b0;
      step(10);

      // Glitch rejection
      btn_up = 1'b1;
      step(3);
      btn_up = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (mov_valid !== 1'b0) seen = 1'b1;
      end
      check("glitch", 32'(seen), 32'd0);

      // Priority: up+down -> UP; left/right arriving in HOLD do not change mov
      btn_up = 1'b1;
      btn_down = 1'b1;
      step(7);
      check_out("prio_ud", 1'b1, 32'd3);
      btn_der = 1'b1;
      btn_izq = 1'b1;
      step(8);
      check_out("prio_hold_stable", 1'b1, 32'd3);
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      check_out("prio_ack", 1'b0, 32'd0);
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_der = 1'b0;
      btn_izq = 1'b0;
      step(10);
      btn_der = 1'b1;
      btn_izq = 1'b1;
      step(7);
      check_out("prio_lr", 1'b1, 32'd1);
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      btn_der = 1'b0;
      btn_izq = 1'b0;
      step(10);

      // Gating with enable
      enable = 1'b0;
      btn_der = 1'b1;
      step(20);
      check_out("gate_off", 1'b0, 32'd0);
      enable = 1'b1;
      step(1);
      check_out("gate_on", 1'b1, 32'd2);
      enable = 1'b0;
      step(1);
      check_out("gate_withdraw", 1'b0, 32'd0);
      enable = 1'b1;
      step(5);
      check_out("gate_no_retrig", 1'b0, 32'd0);
      btn_der = 1'b0;
      step(10);

      // Reset mid-HOLD, button held through reset release
      btn_down = 1'b1;
      step(7);
      check_out("down_valid", 1'b1, 32'd4);
      #2;
      rst = 1'b0;
      #1;
      check_out("async_reset", 1'b0, 32'd0);
      step(1);
      rst = 1'b1;
      step(6);
      check_out("post_rst_early", 1'b0, 32'd0);
      step(1);
      check_out("post_rst_valid", 1'b1, 32'd4);
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      btn_down = 1'b0;
      step(10);

      // Re-press yields a second, distinct HOLD
      btn_izq = 1'b1;
      step(7);
      check_out("repress1", 1'b1, 32'd1);
      mov_ack = 1'b1;
      step(1);
      mov_ack = 1'b0;
      check_out("repress1_ack", 1'b0, 32'd0);
      btn_izq = 1'b0;
      step(10);
      check_out("repress_gap", 1'b0, 32'd0);
      btn_izq = 1'b1;
      step(7);
      check_out("repress2", 1'b1, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
